// File: rtl/wave_param_loader_if.sv
// Word-stream handshake feeding the wave parameter loader.
interface wave_param_loader_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/wave_param_loader.sv
// Shadow/live parameter bank for the eight-channel wave block; decodes a 16-bit
// command stream and retunes every channel together on COMMIT.
package wpl_pkg;
    typedef struct packed {
        logic [15:0] amp;
        logic [15:0] ofs;
        logic [15:0] phw;
    } chan_prm_t;

    typedef enum logic [2:0] {HDR, W_AMP, W_OFS, W_PHW, APPLY} state_t;

    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_COMMIT = 4'h2;
    localparam logic [3:0] OP_CLEAR  = 4'h3;
endpackage

module wpl_chan
    import wpl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  logic      clr,
    input  logic      commit,
    input  chan_prm_t wr_data,
    output chan_prm_t live
);
    chan_prm_t shadow_q, shadow_d;
    chan_prm_t live_q, live_d;

    always_comb begin
        shadow_d = shadow_q;
        live_d   = live_q;
        if (clr)
            shadow_d = '0;
        else if (wr_en)
            shadow_d = wr_data;
        if (commit)
            live_d = shadow_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q <= '0;
            live_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    assign live = live_q;
endmodule

module wave_param_loader
    import wpl_pkg::*;
#(
    parameter int NCHAN   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    wave_param_loader_if.slave     in_if,
    output logic [NCHAN*16-1:0]    amps,
    output logic [NCHAN*16-1:0]    offsets,
    output logic [NCHAN*16-1:0]    phasewords,
    output logic                   commit_pulse,
    output logic                   err
);
    localparam int CHW = $clog2(NCHAN);
    localparam int CW  = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CHW-1:0]   chan_q, chan_d;
    logic [15:0]      amp_q, amp_d;
    logic [15:0]      ofs_q, ofs_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             commit_pulse_q, commit_pulse_d;

    logic             xfer;
    logic             idle_to;
    logic             timeout;
    logic             shadow_wr;
    logic             shadow_clr;
    logic             commit_en;
    logic [3:0]       opcode;
    chan_prm_t        wr_prm;
    chan_prm_t [NCHAN-1:0] live_prm;
    logic             unused_hdr_bits;

    assign xfer            = in_if.in_valid && in_ready_q;
    assign opcode          = in_if.in_data[15:12];
    assign idle_to         = (cnt_q == CW'(TIMEOUT - 1));
    assign unused_hdr_bits = ^in_if.in_data[11:CHW];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= HDR;
            cnt_q          <= '0;
            chan_q         <= '0;
            amp_q          <= '0;
            ofs_q          <= '0;
            err_q          <= 1'b0;
            in_ready_q     <= 1'b0;
            commit_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            chan_q         <= chan_d;
            amp_q          <= amp_d;
            ofs_q          <= ofs_d;
            err_q          <= err_d;
            in_ready_q     <= in_ready_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    // Idle counter only runs while a WRITE is mid-flight; it expires on the
    // idle edge that brings it to TIMEOUT.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            HDR: begin
                if (xfer) begin
                    case (opcode)
                        OP_WRITE:  state_d = W_AMP;
                        OP_COMMIT: state_d = APPLY;
                        default:   state_d = HDR;
                    endcase
                end
            end
            W_AMP, W_OFS, W_PHW: begin
                if (xfer) begin
                    case (state_q)
                        W_AMP:   state_d = W_OFS;
                        W_OFS:   state_d = W_PHW;
                        default: state_d = HDR;
                    endcase
                end else if (idle_to) begin
                    state_d = HDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APPLY:   state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        chan_d         = chan_q;
        amp_d          = amp_q;
        ofs_d          = ofs_q;
        err_d          = err_q;
        shadow_wr      = 1'b0;
        shadow_clr     = 1'b0;
        timeout        = 1'b0;
        commit_en      = (state_q == APPLY);
        commit_pulse_d = (state_q == APPLY);
        in_ready_d     = (state_d != APPLY);

        case (state_q)
            HDR: begin
                if (xfer) begin
                    case (opcode)
                        OP_WRITE:  chan_d = in_if.in_data[CHW-1:0];
                        OP_COMMIT: ;
                        OP_CLEAR: begin
                            shadow_clr = 1'b1;
                            err_d      = 1'b0;
                        end
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            W_AMP: if (xfer) amp_d = in_if.in_data;
            W_OFS: if (xfer) ofs_d = in_if.in_data;
            W_PHW: if (xfer) shadow_wr = 1'b1;
            default: ;
        endcase

        if ((state_q == W_AMP || state_q == W_OFS || state_q == W_PHW) && !xfer && idle_to)
            timeout = 1'b1;
        // An abandoned WRITE leaves nothing behind in the hold register.
        if (timeout) begin
            err_d  = 1'b1;
            chan_d = '0;
            amp_d  = '0;
            ofs_d  = '0;
        end
    end

    assign wr_prm = '{amp: amp_q, ofs: ofs_q, phw: in_if.in_data};

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        wpl_chan u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (shadow_wr && (chan_q == CHW'(k))),
            .clr     (shadow_clr),
            .commit  (commit_en),
            .wr_data (wr_prm),
            .live    (live_prm[k])
        );
        assign amps[16*k +: 16]       = live_prm[k].amp;
        assign offsets[16*k +: 16]    = live_prm[k].ofs;
        assign phasewords[16*k +: 16] = live_prm[k].phw;
    end

    assign in_if.in_ready = in_ready_q;
    assign commit_pulse   = commit_pulse_q;
    assign err            = err_q;
endmodule

// File: tb/tb_wave_param_loader.sv
// Scoreboard bench for wave_param_loader: COMMIT snapshots are queued when sent
// and checked against the live buses while commit_pulse is high.
module tb_wave_param_loader;
    localparam int NCHAN   = 8;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic [127:0] a;
        logic [127:0] o;
        logic [127:0] p;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [127:0] amps, offsets, phasewords;
    logic commit_pulse, err;

    wave_param_loader_if bif ();

    wave_param_loader #(.NCHAN(NCHAN), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (bif.slave),
        .amps         (amps),
        .offsets      (offsets),
        .phasewords   (phasewords),
        .commit_pulse (commit_pulse),
        .err          (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    snap_t exp_q[$];
    snap_t m_live;
    snap_t mon_e;
    logic [15:0] m_amp[NCHAN];
    logic [15:0] m_ofs[NCHAN];
    logic [15:0] m_phw[NCHAN];
    logic [15:0] sq[$];
    logic pulse_prev = 1'b0;

    always @(negedge clk) begin
        if (commit_pulse === 1'b1) begin
            vectors++;
            if (pulse_prev === 1'b1) begin
                miscompares++;
                $display("FAIL commit_pulse_width: high on consecutive cycles, required one cycle");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL commit_pulse_spurious: pulse seen with no COMMIT pending");
            end else begin
                mon_e = exp_q.pop_front();
                if ({amps, offsets, phasewords} !== mon_e) begin
                    miscompares++;
                    $display("FAIL live_at_pulse: amps=%h offs=%h phw=%h required %h %h %h",
                             amps, offsets, phasewords, mon_e.a, mon_e.o, mon_e.p);
                end
            end
        end
        pulse_prev = commit_pulse;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic snap_t shadow_snap();
        snap_t s;
        for (int k = 0; k < NCHAN; k++) begin
            s.a[16*k +: 16] = m_amp[k];
            s.o[16*k +: 16] = m_ofs[k];
            s.p[16*k +: 16] = m_phw[k];
        end
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCHAN; k++) begin
            m_amp[k] = '0;
            m_ofs[k] = '0;
            m_phw[k] = '0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] w);
        int n = 0;
        bif.in_data  = w;
        bif.in_valid = 1'b1;
        while (bif.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n == 20) begin
            miscompares++;
            $display("FAIL handshake: in_ready=%b required 1 within 20 cycles", bif.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    // Full-rate stream: in_valid stays high, stalls only on in_ready.
    task automatic stream();
        while (sq.size() > 0) begin
            int n = 0;
            bif.in_data  = sq.pop_front();
            bif.in_valid = 1'b1;
            while (bif.in_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (n == 20) begin
                miscompares++;
                $display("FAIL stream_handshake: in_ready=%b required 1", bif.in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic write_ch(input int ch, input logic [15:0] junk,
                            input logic [15:0] a, input logic [15:0] o, input logic [15:0] p);
        send(16'h1000 | junk | 16'(ch));
        send(a);
        send(o);
        send(p);
        m_amp[ch] = a;
        m_ofs[ch] = o;
        m_phw[ch] = p;
    endtask

    task automatic do_commit();
        exp_q.push_back(shadow_snap());
        send(16'h2000);
        vectors++;
        if (bif.in_ready !== 1'b0 || commit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL apply_cycle: in_ready=%b commit_pulse=%b required 0 0", bif.in_ready, commit_pulse);
        end
        vectors++;
        if ({amps, offsets, phasewords} !== m_live) begin
            miscompares++;
            $display("FAIL live_early: amps=%h required %h", amps, m_live.a);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || commit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_done: pending=%0d commit_pulse=%b required 0 0", exp_q.size(), commit_pulse);
        end
        m_live = shadow_snap();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        model_clear();
        m_live = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({amps, offsets, phasewords, commit_pulse, err, bif.in_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: amps=%h err=%b pulse=%b ready=%b required all 0",
                     amps, err, commit_pulse, bif.in_ready);
        end
        reset = 1'b1;
        vectors++;
        if (bif.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: in_ready=%b required 0", bif.in_ready);
        end
        @(negedge clk);
        vectors++;
        if (bif.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: in_ready=%b required 1", bif.in_ready);
        end
    endtask

    task automatic test_write_commit();
        write_ch(5, 16'h0000, 16'h7FFF, 16'h0100, 16'h0ABC);
        do_commit();
        vectors++;
        if (amps[95:80] !== 16'h7FFF || offsets[95:80] !== 16'h0100 || phasewords[95:80] !== 16'h0ABC) begin
            miscompares++;
            $display("FAIL ch5_live: amp=%h ofs=%h phw=%h required 7fff 0100 0abc",
                     amps[95:80], offsets[95:80], phasewords[95:80]);
        end
    endtask

    task automatic test_write_no_commit();
        write_ch(2, 16'h0FF8, 16'h8001, 16'h1234, 16'h0042);
        repeat (5) @(negedge clk);
        vectors++;
        if ({amps, offsets, phasewords} !== m_live || amps[47:32] !== 16'h0000) begin
            miscompares++;
            $display("FAIL no_commit_live: ch2 amp=%h required 0000", amps[47:32]);
        end
        do_commit();
        vectors++;
        if (amps[47:32] !== 16'h8001 || phasewords[47:32] !== 16'h0042) begin
            miscompares++;
            $display("FAIL ch2_live: amp=%h phw=%h required 8001 0042", amps[47:32], phasewords[47:32]);
        end
    endtask

    task automatic test_timeout();
        write_ch(0, 16'h0000, 16'h1111, 16'h2222, 16'h3333);
        do_commit();
        send(16'h1000);
        send(16'hAAAA);
        send(16'hBBBB);
        repeat (TIMEOUT - 2) @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: err=%b required 0", err);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (err !== 1'b1 || bif.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_err: err=%b ready=%b required 1 1", err, bif.in_ready);
        end
        do_commit();
        vectors++;
        if (amps[15:0] !== 16'h1111 || offsets[15:0] !== 16'h2222 || phasewords[15:0] !== 16'h3333) begin
            miscompares++;
            $display("FAIL ch0_after_timeout: amp=%h ofs=%h phw=%h required 1111 2222 3333",
                     amps[15:0], offsets[15:0], phasewords[15:0]);
        end
    endtask

    task automatic test_bad_opcode();
        logic [15:0] bad[2];
        bad[0] = 16'hF000;
        bad[1] = 16'h0007;
        send(16'h3000);
        model_clear();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_err: err=%b required 0", err);
        end
        for (int i = 0; i < 2; i++) begin
            send(bad[i]);
            vectors++;
            if (err !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_opcode_%0d: err=%b required 1", i, err);
            end
            send(16'h3000);
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_after_bad_%0d: err=%b required 0", i, err);
            end
        end
        vectors++;
        if ({amps, offsets, phasewords} !== m_live) begin
            miscompares++;
            $display("FAIL clear_keeps_live: amps=%h required %h", amps, m_live.a);
        end
        do_commit();
        vectors++;
        if ({amps, offsets, phasewords} !== '0) begin
            miscompares++;
            $display("FAIL clear_commit_zero: amps=%h offs=%h required 0", amps, offsets);
        end
    endtask

    task automatic test_back_to_back();
        write_ch(3, 16'h0000, 16'h0001, 16'h0002, 16'h0003);
        write_ch(3, 16'h0000, 16'h2000, 16'hF000, 16'h3000);
        write_ch(4, 16'h0AB0, 16'h8000, 16'hFFFF, 16'h1001);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_data_decoded: err=%b required 0", err);
        end
        do_commit();
        vectors++;
        if (amps[63:48] !== 16'h2000 || offsets[63:48] !== 16'hF000 || phasewords[63:48] !== 16'h3000) begin
            miscompares++;
            $display("FAIL last_write_wins: amp=%h ofs=%h phw=%h required 2000 f000 3000",
                     amps[63:48], offsets[63:48], phasewords[63:48]);
        end
        // Two WRITE+COMMIT pairs at full rate; each COMMIT costs one stall.
        m_amp[6] = 16'h0A06; m_ofs[6] = 16'h0B06; m_phw[6] = 16'h0C06;
        exp_q.push_back(shadow_snap());
        m_amp[7] = 16'h0A07; m_ofs[7] = 16'h0B07; m_phw[7] = 16'h0C07;
        exp_q.push_back(shadow_snap());
        sq = '{16'h1006, 16'h0A06, 16'h0B06, 16'h0C06, 16'h2000,
               16'h1007, 16'h0A07, 16'h0B07, 16'h0C07, 16'h2000};
        stream();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_commits: pending=%0d required 0", exp_q.size());
        end
        m_live = shadow_snap();
        vectors++;
        if ({amps, offsets, phasewords} !== m_live) begin
            miscompares++;
            $display("FAIL stream_live: amps=%h required %h", amps, m_live.a);
        end
    endtask

    task automatic test_reset_commit();
        bif.in_data  = 16'h2000;
        bif.in_valid = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        bif.in_valid = 1'b0;
        @(negedge clk);
        model_clear();
        m_live = '0;
        vectors++;
        if ({amps, offsets, phasewords} !== '0 || bif.in_ready !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_commit: amps=%h ready=%b err=%b required 0", amps, bif.in_ready, err);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (commit_pulse !== 1'b0 || {amps, offsets, phasewords} !== '0) begin
                miscompares++;
                $display("FAIL reset_commit_lost_%0d: pulse=%b amps=%h required 0", i, commit_pulse, amps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_write_no_commit();
        test_timeout();
        test_bad_opcode();
        test_back_to_back();
        test_reset_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wave_param_loader.md
# wave_param_loader

Parameter writer for the eight-channel summing wave block: receives a 16-bit word stream over a valid/ready handshake, decodes per-channel write commands, and drives the `amps`, `offsets` and `phasewords` buses (8 × 16 bits each) of the eightblock. Writes land in a shadow bank. A COMMIT command copies the whole shadow bank to the live outputs on a single edge, so all eight oscillators retune together.

## Interface
- `NCHAN`, 8, number of channels; fixed at 8 to match the 128-bit buses.
- `TIMEOUT`, 255, idle cycles allowed between words of one WRITE sequence before it is aborted.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_data`  in  16  command/data word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle; a word transfers when `in_valid && in_ready`.
- `amps`  out  128  live signed amplitudes; channel k at [16k+15:16k].
- `offsets`  out  128  live offsets; same channel mapping.
- `phasewords`  out  128  live phase increments; same channel mapping.
- `commit_pulse`  out  1  high for exactly one cycle after the live buses change.
- `err`  out  1  sticky error flag.

## Operation
- Header word format: [15:12] is the opcode, [2:0] is the channel, [11:3] is ignored.
- Opcode 0x1 WRITE: the header is followed by three data words in this order: amp, offset, phaseword.
- Opcode 0x2 COMMIT: live ← shadow for all channels.
- Opcode 0x3 CLEAR: shadow ← 0 for all channels and `err` ← 0. Live buses are unchanged.
- Any other opcode: the word is consumed and discarded, `err` ← 1, and the FSM stays in HDR.
- FSM states:
  - HDR: waits for a header.
  - W_AMP, W_OFS, W_PHW: collect the three data words of a WRITE.
  - APPLY: performs the COMMIT copy.
- State transitions:
  - HDR + WRITE → W_AMP; the channel number is latched.
  - W_AMP → W_OFS → W_PHW, advancing one state per accepted word.
  - W_PHW on an accepted word → HDR.
  - HDR + COMMIT → APPLY; APPLY → HDR unconditionally after one cycle.
  - HDR + CLEAR → HDR.
- Data words are held in an amp/offset hold register. The shadow entry for the latched channel is written only on the edge that accepts the phaseword, so a partial WRITE never alters the shadow bank.
- Timeout: in W_AMP, W_OFS or W_PHW, an idle counter increments on every cycle with no accepted word and clears on every accepted word. When the counter reaches `TIMEOUT`, the FSM goes to HDR, `err` ← 1, and the hold register is discarded. The counter is held at 0 in HDR and APPLY.
- Data words are raw. Their value is never decoded as an opcode.
- Back-to-back WRITEs to the same channel: the last complete WRITE wins. Channels not written keep their previous shadow value.

## Timing
- Reset (`reset` low at an edge) sets all of the following:
  - `amps`, `offsets`, `phasewords` = 0.
  - Shadow bank and hold register = 0.
  - State = HDR, idle counter = 0.
  - `commit_pulse` = 0, `err` = 0, `in_ready` = 0.
- Reset has priority over every other event, including a reset asserted mid-WRITE or in APPLY; a pending WRITE or COMMIT is lost.
- `in_ready` is registered:
  - It is 1 at the first edge after `reset` is released.
  - It is 0 during the APPLY cycle and 1 in all other states.
- COMMIT latency:
  - Header accepted at edge N; APPLY occupies cycle N→N+1.
  - Live buses take the new value at edge N+1.
  - `commit_pulse` is high from N+1 to N+2.
- A WRITE completing at edge M is visible to a COMMIT header accepted at edge M+1 or later.
- Minimum WRITE length is 4 consecutive cycles.
- Full-rate stream rule: a COMMIT costs one stall cycle (`in_ready` low). No words are dropped.
- `err` set and CLEAR in the same cycle cannot occur, because only one word transfers per cycle.

## Test plan
- Reset then idle: all buses are 0, `err` = 0, `commit_pulse` = 0, and `in_ready` rises one cycle after `reset` goes high.
- WRITE channel 5 (0x1005, 0x7FFF, 0x0100, 0x0ABC) then COMMIT (0x2000) → `amps`[95:80] = 0x7FFF, `offsets`[95:80] = 0x0100 and `phasewords`[95:80] = 0x0ABC at edge N+1. Other channels remain 0, `commit_pulse` is high for one cycle, and `in_ready` is low during APPLY.
- WRITE channel 2 without COMMIT → live buses stay 0. A later COMMIT applies it.
- WRITE channel 0 stalled after the offset word for `TIMEOUT` cycles → `err` = 1 and the FSM returns to HDR. A following COMMIT leaves channel 0 at its prior value.
- Opcode 0xF000 → `err` = 1. A subsequent CLEAR (0x3000) gives `err` = 0, and a following COMMIT zeroes all live buses.
- Assert `reset` on the cycle a COMMIT header is accepted → live buses stay 0 and `commit_pulse` never rises.
